instr_decode_queue: RTL and testbench

Parametrised instruction buffer and decode stage for the 9-bit CPU. It sits between instruction memory fetch and the execute/register-file control. Instruction words are accepted over a valid/ready handshake, held in a DEPTH-entry FIFO, and presented one per cycle as a registered, pre-decoded bundle: opcode, operand, class and illegal flag. It also supports pipeline flush on taken branch and optional fusion of `vall`+`valh` pairs into a single 8-bit immediate.

---
 rtl/instr_decode_queue_if.sv | 34 +++
 rtl/instr_decode_queue.sv | 175 +++++++++++++++++
 tb/tb_instr_decode_queue.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_decode_queue_if.sv
// Handshake bundle for instr_decode_queue: fetch-side input and decoded output.
// slave is the queue's view, master is the fetch/consumer side.
interface instr_decode_queue_if #(
    parameter int unsigned OPW  = 5,
    parameter int unsigned ARGW = 4,
    parameter int unsigned PCW  = 8
);
    logic                   in_valid;
    logic                   in_ready;
    logic [OPW+ARGW-1:0]    in_word;
    logic [PCW-1:0]         in_pc;

    logic                   out_valid;
    logic                   out_ready;
    logic [OPW-1:0]         out_op;
    logic [ARGW-1:0]        out_arg;
    logic [2:0]             out_cls;
    logic                   out_illegal;
    logic [2*ARGW-1:0]      out_imm;
    logic                   out_fused;
    logic [PCW-1:0]         out_pc;

    modport slave (
        input  in_valid, in_word, in_pc, out_ready,
        output in_ready, out_valid, out_op, out_arg, out_cls, out_illegal,
               out_imm, out_fused, out_pc
    );

    modport master (
        output in_valid, in_word, in_pc, out_ready,
        input  in_ready, out_valid, out_op, out_arg, out_cls, out_illegal,
               out_imm, out_fused, out_pc
    );
endinterface

// File: rtl/instr_decode_queue.sv
// Instruction buffer + registered decode stage for the 9-bit CPU.
// DEPTH-entry FIFO followed by one output register; an empty queue bypasses
// the incoming word straight into the output register.
// Optional feature: define INSTR_DQ_FUSE_EN to fuse a vall+valh pair waiting
// in the FIFO into a single bundle carrying an 8-bit immediate.
module instr_decode_queue #(
    parameter int unsigned OPW   = 5,
    parameter int unsigned ARGW  = 4,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PCW   = 8
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_flush,
    instr_decode_queue_if.slave     bus,
    output logic [$clog2(DEPTH):0]  o_count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned WW = OPW + ARGW;

    typedef struct packed {
        logic [WW-1:0]  word;
        logic [PCW-1:0] pc;
    } entry_t;

    entry_t              r_mem [DEPTH];
    logic [AW:0]         r_wptr;
    logic [AW:0]         r_rptr;
    logic                r_out_valid;
    logic [OPW-1:0]      r_op;
    logic [ARGW-1:0]     r_arg;
    logic [2:0]          r_cls;
    logic                r_illegal;
    logic [2*ARGW-1:0]   r_imm;
    logic [PCW-1:0]      r_pc;

    logic [AW:0]         w_count;
    logic                w_empty;
    logic                w_full;
    logic                w_push;
    logic                w_pop;
    logic                w_load;
    logic                w_load_fifo;
    logic                w_bypass;
    logic                w_wr;
    logic                w_fuse;
    logic [AW:0]         w_rd_inc;
    entry_t              w_head;
    entry_t              w_src;
    logic [OPW-1:0]      w_src_op;
    logic [ARGW-1:0]     w_src_arg;
    logic [2:0]          w_cls;
    logic                w_illegal;
    logic [2*ARGW-1:0]   w_imm;

    // Class decode: returns {illegal, cls}.
    function automatic logic [3:0] f_decode(input logic [OPW-1:0] op);
        int unsigned v;
        v = 32'(op);
        if (v <= 1)       return 4'b0_000;
        else if (v <= 15) return 4'b0_001;
        else if (v <= 17) return 4'b0_010;
        else if (v <= 19) return 4'b0_011;
        else if (v <= 24) return 4'b0_100;
        else if (v == 25) return 4'b1_111;
        else if (v <= 27) return 4'b0_101;
        else if (v <= 30) return 4'b0_110;
        else              return 4'b0_111;
    endfunction

    // in_ready comes from registered pointers only, so a pop at full never frees a slot early.
    assign w_count      = r_wptr - r_rptr;
    assign w_empty      = (w_count == '0);
    assign w_full       = (w_count == (AW+1)'(DEPTH));
    assign bus.in_ready = !w_full;
    assign o_count      = w_count;

    assign w_push      = bus.in_valid && !w_full && !i_flush && !i_reset;
    assign w_pop       = r_out_valid && bus.out_ready;
    assign w_load      = !r_out_valid || w_pop;
    assign w_load_fifo = w_load && !w_empty;
    assign w_bypass    = w_load && w_empty && w_push;
    assign w_wr        = w_push && !w_bypass;

    assign w_head    = r_mem[r_rptr[AW-1:0]];
    assign w_src     = w_load_fifo ? w_head : {bus.in_word, bus.in_pc};
    assign w_src_op  = w_src.word[WW-1:ARGW];
    assign w_src_arg = w_src.word[ARGW-1:0];

`ifdef INSTR_DQ_FUSE_EN
    localparam logic [OPW-1:0] OP_VALL = '0;
    localparam logic [OPW-1:0] OP_VALH = OPW'(1);

    logic [WW-1:0] w_next_word;
    logic          r_fused;

    assign w_next_word = r_mem[r_rptr[AW-1:0] + AW'(1)].word;
    // Fusion only looks at FIFO contents; a lone vall is never held back.
    assign w_fuse = (w_count >= (AW+1)'(2)) && (w_head.word[WW-1:ARGW] == OP_VALL) &&
                    (w_next_word[WW-1:ARGW] == OP_VALH);
    assign w_imm  = w_fuse ? {w_next_word[ARGW-1:0], w_head.word[ARGW-1:0]}
                           : {{ARGW{1'b0}}, w_src_arg};
    assign bus.out_fused = r_fused;
`else
    assign w_fuse        = 1'b0;
    assign w_imm         = {{ARGW{1'b0}}, w_src_arg};
    assign bus.out_fused = 1'b0;
`endif

    // Read pointer advance: one entry normally, two when a pair is fused.
    assign w_rd_inc = !w_load_fifo ? '0 : (w_fuse ? (AW+1)'(2) : (AW+1)'(1));

    // Decode the word being loaded into the output register.
    always_comb begin
        w_cls     = 3'd0;
        w_illegal = 1'b0;
        {w_illegal, w_cls} = f_decode(w_src_op);
    end

    // FIFO storage; contents need no reset since pointers define validity.
    always_ff @(posedge i_clk) begin
        if (w_wr) begin
            r_mem[r_wptr[AW-1:0]] <= {bus.in_word, bus.in_pc};
        end
    end

    // Pointers and output stage; reset beats flush, flush drops everything in flight.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_out_valid <= 1'b0;
            r_op        <= '0;
            r_arg       <= '0;
            r_cls       <= '0;
            r_illegal   <= 1'b0;
            r_imm       <= '0;
            r_pc        <= '0;
`ifdef INSTR_DQ_FUSE_EN
            r_fused     <= 1'b0;
`endif
        end else if (i_flush) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + (AW+1)'(1);
            end
            r_rptr <= r_rptr + w_rd_inc;
            if (w_load) begin
                r_out_valid <= w_load_fifo || w_bypass;
                if (w_load_fifo || w_bypass) begin
                    r_op      <= w_src_op;
                    r_arg     <= w_src_arg;
                    r_cls     <= w_cls;
                    r_illegal <= w_illegal;
                    r_imm     <= w_imm;
                    r_pc      <= w_src.pc;
`ifdef INSTR_DQ_FUSE_EN
                    r_fused   <= w_fuse;
`endif
                end
            end
        end
    end

    assign bus.out_valid   = r_out_valid;
    assign bus.out_op      = r_op;
    assign bus.out_arg     = r_arg;
    assign bus.out_cls     = r_cls;
    assign bus.out_illegal = r_illegal;
    assign bus.out_imm     = r_imm;
    assign bus.out_pc      = r_pc;
endmodule

// File: tb/tb_instr_decode_queue.sv
// Self-checking bench for instr_decode_queue: decode table, directed corner
// sequences, then randomized push/pop/flush against a scoreboard queue.
module tb_instr_decode_queue;
    localparam int unsigned OPW   = 5;
    localparam int unsigned ARGW  = 4;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned PCW   = 8;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    logic          clk   = 1'b0;
    logic          reset = 1'b1;
    logic          flush = 1'b0;
    logic [CW-1:0] count;

    instr_decode_queue_if #(.OPW(OPW), .ARGW(ARGW), .PCW(PCW)) bus ();

    instr_decode_queue #(.OPW(OPW), .ARGW(ARGW), .DEPTH(DEPTH), .PCW(PCW)) dut (
        .i_clk   (clk),
        .i_reset (reset),
        .i_flush (flush),
        .bus     (bus),
        .o_count (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] op;
        logic [3:0] arg;
        logic [7:0] pc;
    } sb_t;

    typedef struct {
        logic [8:0] word;
        logic [7:0] pc;
        logic [4:0] op;
        logic [3:0] arg;
        logic [2:0] cls;
        logic       ill;
    } vec_t;

    sb_t  sb [$];
    vec_t vecs [16];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_pops   = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    // Reference class table, returns {illegal, cls}.
    function automatic logic [3:0] ref_dec(input logic [4:0] op);
        case (op) inside
            [5'd0:5'd1]:   return {1'b0, 3'd0};
            [5'd2:5'd15]:  return {1'b0, 3'd1};
            [5'd16:5'd17]: return {1'b0, 3'd2};
            [5'd18:5'd19]: return {1'b0, 3'd3};
            [5'd20:5'd24]: return {1'b0, 3'd4};
            5'd25:         return {1'b1, 3'd7};
            [5'd26:5'd27]: return {1'b0, 3'd5};
            [5'd28:5'd30]: return {1'b0, 3'd6};
            default:       return {1'b0, 3'd7};
        endcase
    endfunction

    function automatic logic [63:0] pack(input logic [4:0] op, input logic [3:0] arg,
                                         input logic [2:0] cls, input logic ill,
                                         input logic [7:0] imm, input logic fused,
                                         input logic [7:0] pc);
        return {34'b0, op, arg, cls, ill, imm, fused, pc};
    endfunction

    function automatic logic [63:0] dut_bundle();
        return pack(bus.out_op, bus.out_arg, bus.out_cls, bus.out_illegal, bus.out_imm,
                    bus.out_fused, bus.out_pc);
    endfunction

    // Observe the cycle about to be clocked: compare pops, then record pushes.
    task automatic mon();
        sb_t        e0;
        logic [3:0] d;
`ifdef INSTR_DQ_FUSE_EN
        sb_t        e1;
`endif
        if (reset || flush) begin
            sb.delete();
            return;
        end
        check("count_le_depth", 64'(count <= CW'(DEPTH)), 64'(1));
        check("in_ready_rule", 64'(bus.in_ready), 64'(count < CW'(DEPTH)));
        if (bus.out_valid && bus.out_ready) begin
            n_pops++;
            check("pop_has_expected", 64'(sb.size() != 0), 64'(1));
            if (sb.size() != 0) begin
                e0 = sb.pop_front();
`ifdef INSTR_DQ_FUSE_EN
                if (bus.out_fused) begin
                    check("fuse_has_pair", 64'(sb.size() != 0), 64'(1));
                    if (sb.size() != 0) begin
                        e1 = sb.pop_front();
                        check("fuse_pair_ops", 64'({e0.op, e1.op}), 64'({5'd0, 5'd1}));
                        check("fused_bundle", dut_bundle(),
                              pack(5'd0, e0.arg, 3'd0, 1'b0, {e1.arg, e0.arg}, 1'b1, e0.pc));
                    end
                end else
`endif
                begin
                    d = ref_dec(e0.op);
                    check("bundle", dut_bundle(),
                          pack(e0.op, e0.arg, d[2:0], d[3], {4'b0, e0.arg}, 1'b0, e0.pc));
                end
            end
        end
        if (bus.in_valid && bus.in_ready) begin
            sb.push_back('{op: bus.in_word[8:4], arg: bus.in_word[3:0], pc: bus.in_pc});
        end
    endtask

    task automatic tick();
        @(negedge clk);
        mon();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [8:0] w, input logic [7:0] p,
                         input logic rdy);
        bus.in_valid  = v;
        bus.in_word   = w;
        bus.in_pc     = p;
        bus.out_ready = rdy;
    endtask

    task automatic drain(input string nm);
        drive(1'b0, 9'h0, 8'h0, 1'b1);
        for (int k = 0; k < 20 && (bus.out_valid || count != 0); k++) tick();
        check(nm, 64'({bus.out_valid, count}), 64'(0));
    endtask

    initial begin
        int          pops0;
        logic [8:0]  w;
        int unsigned r;

        vecs[0]  = '{9'h003, 8'h01, 5'd0,  4'h3, 3'd0, 1'b0};
        vecs[1]  = '{9'h01F, 8'h02, 5'd1,  4'hF, 3'd0, 1'b0};
        vecs[2]  = '{9'h027, 8'h03, 5'd2,  4'h7, 3'd1, 1'b0};
        vecs[3]  = '{9'h0F1, 8'h04, 5'd15, 4'h1, 3'd1, 1'b0};
        vecs[4]  = '{9'h102, 8'h05, 5'd16, 4'h2, 3'd2, 1'b0};
        vecs[5]  = '{9'h11A, 8'h06, 5'd17, 4'hA, 3'd2, 1'b0};
        vecs[6]  = '{9'h125, 8'h07, 5'd18, 4'h5, 3'd3, 1'b0};
        vecs[7]  = '{9'h13B, 8'h08, 5'd19, 4'hB, 3'd3, 1'b0};
        vecs[8]  = '{9'h140, 8'h09, 5'd20, 4'h0, 3'd4, 1'b0};
        vecs[9]  = '{9'h18E, 8'h0A, 5'd24, 4'hE, 3'd4, 1'b0};
        vecs[10] = '{9'h190, 8'h0B, 5'd25, 4'h0, 3'd7, 1'b1};
        vecs[11] = '{9'h1A3, 8'h0C, 5'd26, 4'h3, 3'd5, 1'b0};
        vecs[12] = '{9'h1BC, 8'h0D, 5'd27, 4'hC, 3'd5, 1'b0};
        vecs[13] = '{9'h1C6, 8'h0E, 5'd28, 4'h6, 3'd6, 1'b0};
        vecs[14] = '{9'h1E9, 8'h0F, 5'd30, 4'h9, 3'd6, 1'b0};
        vecs[15] = '{9'h1FD, 8'h10, 5'd31, 4'hD, 3'd7, 1'b0};

        drive(1'b0, 9'h0, 8'h0, 1'b0);
        tick();
        tick();
        reset = 1'b0;
        check("reset_out_valid", 64'(bus.out_valid), 64'(0));
        check("reset_in_ready", 64'(bus.in_ready), 64'(1));
        check("reset_count", 64'(count), 64'(0));
        check("reset_fields", dut_bundle(), 64'(0));

        // Bypass latency on an idle queue.
        drive(1'b1, 9'h1A3, 8'h10, 1'b0);
        tick();
        drive(1'b0, 9'h0, 8'h0, 1'b0);
        check("bypass_valid", 64'(bus.out_valid), 64'(1));
        check("bypass_bundle", dut_bundle(), pack(5'h1A, 4'h3, 3'd5, 1'b0, 8'h03, 1'b0, 8'h10));
        check("bypass_count", 64'(count), 64'(0));
        drain("bypass_drain");

        // Decode table, one word at a time.
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, vecs[i].word, vecs[i].pc, 1'b1);
            tick();
            drive(1'b0, 9'h0, 8'h0, 1'b1);
            check($sformatf("decode_%0d", i), 64'({bus.out_valid, dut_bundle()[29:0]}),
                  64'({1'b1, pack(vecs[i].op, vecs[i].arg, vecs[i].cls, vecs[i].ill,
                                   {4'b0, vecs[i].arg}, 1'b0, vecs[i].pc)[29:0]}));
            tick();
        end

        // Fill to capacity under stall, then release.
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 9'h020 + 9'(i), 8'h20 + 8'(i), 1'b0);
            tick();
        end
        drive(1'b0, 9'h0, 8'h0, 1'b0);
        check("full_state", 64'({bus.in_ready, count}), 64'({1'b0, CW'(4)}));
        drive(1'b1, 9'h1FF, 8'hEE, 1'b1);
        tick();
        check("after_first_pop", 64'({bus.in_ready, count}), 64'({1'b1, CW'(3)}));
        drain("fill_drain");

        // vall/valh pair waiting behind a stalled bundle.
        drive(1'b1, 9'h1A3, 8'h30, 1'b0);
        tick();
        drive(1'b1, 9'h005, 8'h40, 1'b0);
        tick();
        drive(1'b1, 9'h01C, 8'h41, 1'b0);
        tick();
        pops0 = n_pops;
        drain("fuse_drain");
`ifdef INSTR_DQ_FUSE_EN
        check("fuse_bundle_count", 64'(n_pops - pops0), 64'(2));
`else
        check("fuse_bundle_count", 64'(n_pops - pops0), 64'(3));
`endif

        // Flush with a full-ish queue and a word offered in the flush cycle.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 9'h030 + 9'(i), 8'h50 + 8'(i), 1'b0);
            tick();
        end
        check("pre_flush_count", 64'({bus.out_valid, count}), 64'({1'b1, CW'(3)}));
        flush = 1'b1;
        drive(1'b1, 9'h0FF, 8'h66, 1'b0);
        tick();
        flush = 1'b0;
        drive(1'b0, 9'h0, 8'h0, 1'b0);
        check("post_flush", 64'({bus.out_valid, bus.in_ready, count}), 64'({2'b01, CW'(0)}));
        pops0 = n_pops;
        drive(1'b1, 9'h1A3, 8'h77, 1'b1);
        tick();
        drain("post_flush_drain");
        check("post_flush_one_bundle", 64'(n_pops - pops0), 64'(1));

        // Random traffic against the scoreboard.
        for (int c = 0; c < 10000; c++) begin
            r = $urandom_range(0, 3);
            w = 9'($urandom_range(0, 511));
            if (r == 0) w[8:4] = 5'd0;
            else if (r == 1) w[8:4] = 5'd1;
            flush = ($urandom_range(0, 63) == 0);
            drive($urandom_range(0, 9) < 7, w, 8'($urandom_range(0, 255)),
                  flush ? 1'b0 : ($urandom_range(0, 9) < 6));
            tick();
        end
        flush = 1'b0;
        drain("random_drain");
        check("random_no_loss", 64'(sb.size()), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
